// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment display blocks: segment table, idle codes, scan states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fnd_pkg;

    // Active-low idle codes for the common and segment pins.
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] COM_OFF = 4'b1111;

    // Segment pattern used for a suppressed leading zero (dp bit is added separately).
    localparam logic [6:0] SEG_DARK = 7'h7F;

    typedef enum logic {
        BLANK   = 1'b0,
        DISPLAY = 1'b1
    } scan_state_t;

    // Hex nibble -> active-low {g,f,e,d,c,b,a}; element [n] is the pattern for nibble n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/fnd_scan_cntr_if.sv
// Display-side bundle: scan control/data inputs and the active-low FND pin outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the display consumes its inputs continuously.
// Ports: enable, value[15:0], dp_in[3:0], blank_lz toward the driver; com[3:0], seg_7[7:0] from it.
interface fnd_scan_cntr_if;

    logic        enable;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  com;
    logic [7:0]  seg_7;

    // Driver side (the scan controller).
    modport slave (
        input  enable,
        input  value,
        input  dp_in,
        input  blank_lz,
        output com,
        output seg_7
    );

    // Source side (counter stages / bench).
    modport master (
        output enable,
        output value,
        output dp_in,
        output blank_lz,
        input  com,
        input  seg_7
    );

endinterface

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: hex[3:0] in, seg[6:0] out.
module seg7_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[hex];

endmodule

// File: rtl/fnd_scan_cntr.sv
// 4-digit common-anode FND scan driver: ring-scans digits with blank gaps, hex decode, LZ blanking.
// Latency: outputs registered; com/seg_7 reflect the scan state entered on the same clock edge.
// Backpressure: none; enable=0 darkens the display and freezes the scan until re-enabled.
// Ports: clk, reset_p (sync, active-high), bus (slave modport: enable/value/dp_in/blank_lz -> com/seg_7).
module fnd_scan_cntr #(
    parameter int SCAN_PERIOD = 100_000,
    parameter int BLANK_CYC   = 64
) (
    input  logic            clk,
    input  logic            reset_p,
    fnd_scan_cntr_if.slave  bus
);

    import fnd_pkg::*;

    localparam int SW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int BW = (BLANK_CYC   > 1) ? $clog2(BLANK_CYC)   : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_PERIOD - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    // Scan state
    scan_state_t   state,     state_nxt;
    logic [1:0]    idx,       idx_nxt;
    logic [SW-1:0] scan_cnt,  scan_nxt;
    logic [BW-1:0] blank_cnt, blank_nxt;

    // Frame snapshot
    logic [15:0]   snap_val,  snap_val_nxt;
    logic [3:0]    snap_dp,   snap_dp_nxt;
    logic          snap_blz,  snap_blz_nxt;
    logic          capture;

    // Output path
    logic [3:0]    com_q,     com_nxt;
    logic [7:0]    seg_q,     seg_nxt;
    logic [3:0]    digit;
    logic [6:0]    dec_seg;
    logic [3:0]    lz;
    logic          z3, z2, z1;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state     <= BLANK;
            idx       <= '0;
            scan_cnt  <= '0;
            blank_cnt <= '0;
            snap_val  <= '0;
            snap_dp   <= '0;
            snap_blz  <= 1'b0;
            com_q     <= COM_OFF;
            seg_q     <= SEG_OFF;
        end else if (bus.enable) begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            scan_cnt  <= scan_nxt;
            blank_cnt <= blank_nxt;
            snap_val  <= snap_val_nxt;
            snap_dp   <= snap_dp_nxt;
            snap_blz  <= snap_blz_nxt;
            com_q     <= com_nxt;
            seg_q     <= seg_nxt;
        end else begin
            // Dark but frozen: scan position and counters resume where they stopped.
            com_q     <= COM_OFF;
            seg_q     <= SEG_OFF;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        scan_nxt  = scan_cnt;
        blank_nxt = blank_cnt;
        capture   = 1'b0;

        case (state)
            BLANK: begin
                // With no blank gap configured this state only exists right after reset.
                if ((BLANK_CYC == 0) || (blank_cnt == BLANK_LAST)) begin
                    state_nxt = DISPLAY;
                    blank_nxt = '0;
                    scan_nxt  = '0;
                    capture   = (idx == 2'd0);
                end else begin
                    blank_nxt = blank_cnt + BW'(1);
                end
            end
            DISPLAY: begin
                if (scan_cnt == SCAN_LAST) begin
                    idx_nxt  = idx + 2'd1;
                    scan_nxt = '0;
                    if (BLANK_CYC == 0) begin
                        // Straight into the next digit; frame starts when digit 3 wraps.
                        state_nxt = DISPLAY;
                        capture   = (idx == 2'd3);
                    end else begin
                        state_nxt = BLANK;
                    end
                end else begin
                    scan_nxt = scan_cnt + SW'(1);
                end
            end
            default: begin
                state_nxt = BLANK;
            end
        endcase
    end

    // Inputs are only sampled at the start of a frame so all four digits come from one value.
    always_comb begin
        snap_val_nxt = snap_val;
        snap_dp_nxt  = snap_dp;
        snap_blz_nxt = snap_blz;
        if (capture) begin
            snap_val_nxt = bus.value;
            snap_dp_nxt  = bus.dp_in;
            snap_blz_nxt = bus.blank_lz;
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero; digit 0 never is.
    assign z3 = (snap_val_nxt[15:12] == 4'h0);
    assign z2 = (snap_val_nxt[11:8]  == 4'h0);
    assign z1 = (snap_val_nxt[7:4]   == 4'h0);
    assign lz = {z3, z3 & z2, z3 & z2 & z1, 1'b0} & {4{snap_blz_nxt}};

    assign digit = snap_val_nxt[{idx_nxt, 2'b00} +: 4];

    seg7_decoder u_dec (
        .hex (digit),
        .seg (dec_seg)
    );

    // Outputs are computed from the incoming state so the pins line up with the state register.
    always_comb begin
        com_nxt = COM_OFF;
        seg_nxt = SEG_OFF;
        if (state_nxt == DISPLAY) begin
            com_nxt = ~(4'b0001 << idx_nxt);
            seg_nxt = {~snap_dp_nxt[idx_nxt], lz[idx_nxt] ? SEG_DARK : dec_seg};
        end
    end

    assign bus.com   = com_q;
    assign bus.seg_7 = seg_q;

endmodule

// File: tb/tb_fnd_scan_cntr.sv
// Bench for fnd_scan_cntr: table-driven cycle vectors on a 4/2 instance plus a 1/0 rotation sequence.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_fnd_scan_cntr;

    logic clk;
    logic rst_a;
    logic rst_b;

    fnd_scan_cntr_if if_a ();
    fnd_scan_cntr_if if_b ();

    fnd_scan_cntr #(.SCAN_PERIOD(4), .BLANK_CYC(2)) dut_a (
        .clk     (clk),
        .reset_p (rst_a),
        .bus     (if_a)
    );

    fnd_scan_cntr #(.SCAN_PERIOD(1), .BLANK_CYC(0)) dut_b (
        .clk     (clk),
        .reset_p (rst_b),
        .bus     (if_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] val;
        logic [3:0]  dp;
        logic        blz;
        int          n;
        logic [3:0]  com;
        logic [7:0]  seg;
    } vec_t;

    vec_t tbl[$];

    int total;
    int bad;

    // Inputs held by subsequent expectation rows until changed.
    logic        c_rst;
    logic        c_en;
    logic [15:0] c_val;
    logic [3:0]  c_dp;
    logic        c_blz;

    task automatic setin(input logic r, input logic e, input logic [15:0] v,
                         input logic [3:0] d, input logic b);
        c_rst = r; c_en = e; c_val = v; c_dp = d; c_blz = b;
    endtask

    task automatic exp(input int n, input logic [3:0] cm, input logic [7:0] sg);
        vec_t v;
        v.rst = c_rst; v.en = c_en; v.val = c_val; v.dp = c_dp; v.blz = c_blz;
        v.n = n; v.com = cm; v.seg = sg;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    localparam logic [3:0] OFF = 4'b1111;
    localparam logic [3:0] D0  = 4'b1110;
    localparam logic [3:0] D1  = 4'b1101;
    localparam logic [3:0] D2  = 4'b1011;
    localparam logic [3:0] D3  = 4'b0111;

    logic [3:0] b_com [4];
    logic [7:0] b_seg [4];

    initial begin
        total = 0;
        bad   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.enable = 1'b1; if_a.value = 16'h1234; if_a.dp_in = 4'h0; if_a.blank_lz = 1'b0;
        if_b.enable = 1'b1; if_b.value = 16'h1234; if_b.dp_in = 4'h0; if_b.blank_lz = 1'b0;

        // Reset and one full frame of 1234: 24 cycles from leaving reset.
        setin(1, 1, 16'h1234, 4'h0, 0); exp(1, OFF, 8'hFF);
        setin(0, 1, 16'h1234, 4'h0, 0); exp(1, OFF, 8'hFF);
        exp(4, D0, 8'h99); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hB0); exp(2, OFF, 8'hFF);
        exp(4, D2, 8'hA4); exp(2, OFF, 8'hFF);
        exp(4, D3, 8'hF9); exp(2, OFF, 8'hFF);
        // Value changes while digit 1 is lit: rest of frame keeps old sample.
        exp(4, D0, 8'h99); exp(2, OFF, 8'hFF);
        exp(1, D1, 8'hB0);
        setin(0, 1, 16'hABCD, 4'h0, 0);
        exp(3, D1, 8'hB0); exp(2, OFF, 8'hFF);
        exp(4, D2, 8'hA4); exp(2, OFF, 8'hFF);
        exp(4, D3, 8'hF9); exp(2, OFF, 8'hFF);
        exp(4, D0, 8'hA1); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hC6); exp(2, OFF, 8'hFF);
        exp(4, D2, 8'h83); exp(2, OFF, 8'hFF);
        exp(4, D3, 8'h88); exp(2, OFF, 8'hFF);
        // Enable dropped for 10 cycles after digit 2 has been lit one cycle.
        exp(4, D0, 8'hA1); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hC6); exp(2, OFF, 8'hFF);
        exp(1, D2, 8'h83);
        setin(0, 0, 16'hABCD, 4'h0, 0); exp(10, OFF, 8'hFF);
        setin(0, 1, 16'hABCD, 4'h0, 0); exp(3, D2, 8'h83);
        exp(2, OFF, 8'hFF);
        exp(4, D3, 8'h88); exp(2, OFF, 8'hFF);
        // Leading-zero suppression with a dp on a blanked digit.
        setin(0, 1, 16'h0005, 4'b0100, 1);
        exp(4, D0, 8'h92); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hFF); exp(2, OFF, 8'hFF);
        exp(4, D2, 8'h7F); exp(2, OFF, 8'hFF);
        exp(4, D3, 8'hFF); exp(2, OFF, 8'hFF);
        // Embedded zero is not a leading zero; dp on digit 0.
        setin(0, 1, 16'h0305, 4'b0001, 1);
        exp(4, D0, 8'h12); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hC0); exp(2, OFF, 8'hFF);
        exp(4, D2, 8'hB0); exp(2, OFF, 8'hFF);
        exp(4, D3, 8'hFF); exp(2, OFF, 8'hFF);
        // Value 0 with suppression still shows digit 0.
        setin(0, 1, 16'h0000, 4'h0, 1);
        exp(4, D0, 8'hC0); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hFF); exp(2, OFF, 8'hFF);
        exp(4, D2, 8'hFF); exp(2, OFF, 8'hFF);
        exp(4, D3, 8'hFF); exp(2, OFF, 8'hFF);
        // Reset in the middle of digit 3: restart at digit 0 after the blank gap.
        setin(0, 1, 16'h1234, 4'h0, 0);
        exp(4, D0, 8'h99); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hB0); exp(2, OFF, 8'hFF);
        exp(4, D2, 8'hA4); exp(2, OFF, 8'hFF);
        exp(2, D3, 8'hF9);
        setin(1, 1, 16'h1234, 4'h0, 0); exp(1, OFF, 8'hFF);
        setin(0, 1, 16'h1234, 4'h0, 0); exp(1, OFF, 8'hFF);
        exp(4, D0, 8'h99); exp(2, OFF, 8'hFF);
        exp(4, D1, 8'hB0);

        for (int i = 0; i < tbl.size(); i++) begin
            rst_a         = tbl[i].rst;
            if_a.enable   = tbl[i].en;
            if_a.value    = tbl[i].val;
            if_a.dp_in    = tbl[i].dp;
            if_a.blank_lz = tbl[i].blz;
            for (int c = 0; c < tbl[i].n; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("a_com row%0d cyc%0d", i, c), {4'h0, if_a.com}, {4'h0, tbl[i].com});
                chk($sformatf("a_seg row%0d cyc%0d", i, c), if_a.seg_7, tbl[i].seg);
            end
        end

        // No blank gap, one cycle per digit: rotation every cycle after reset.
        b_com[0] = D0; b_com[1] = D1; b_com[2] = D2; b_com[3] = D3;
        b_seg[0] = 8'h99; b_seg[1] = 8'hB0; b_seg[2] = 8'hA4; b_seg[3] = 8'hF9;
        @(posedge clk);
        #1;
        chk("b_reset_com", {4'h0, if_b.com}, {4'h0, OFF});
        chk("b_reset_seg", if_b.seg_7, 8'hFF);
        rst_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b_com cyc%0d", k), {4'h0, if_b.com}, {4'h0, b_com[k % 4]});
            chk($sformatf("b_seg cyc%0d", k), if_b.seg_7, b_seg[k % 4]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
